// File: rtl/miriscv_rf_bist_pkg.sv
// Shared definitions for the register-file BIST: FSM encoding, LFSR polynomial,
// register-file geometry and the LFSR next-state function.
package miriscv_rf_bist_pkg;

  // BIST controller states; encoding is fixed so software/debug views stay stable
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StDone  = 2'd3
  } bist_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_AW     = 5;

  // Highest register index; the phase change is decided on this value, never on wrap-around
  localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(RF_DEPTH - 1);

  localparam int unsigned ERR_W   = 7;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Galois right-shift step: feed the polynomial back whenever a one falls out of bit 0
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/miriscv_lfsr32.sv
// 32-bit Galois LFSR with synchronous reload. Reset and load both restore the seed;
// load wins over step so the controller can restart the sequence on any cycle.
module miriscv_lfsr32
  import miriscv_rf_bist_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] q_o
);

  logic [31:0] lfsr_q;

  // Seed on reset/load, otherwise advance one step when requested
  always_ff @(posedge clk_i) begin
    if (reset) begin
      lfsr_q <= seed_i;
    end else if (load_i) begin
      lfsr_q <= seed_i;
    end else if (step_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/miriscv_rf_bist.sv
// Register-file BIST initiator. Fills every register with an LFSR word, then reads
// each register on both read ports and compares against a regenerated LFSR stream.
// Reports pass/fail, a saturating mismatch count and the first failing address.
module miriscv_rf_bist
  import miriscv_rf_bist_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter bit          SKIP_X0 = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             start_i,
  output logic [RF_AW-1:0] rf_addr1_o,
  output logic [RF_AW-1:0] rf_addr2_o,
  output logic [RF_AW-1:0] rf_addr3_o,
  output logic [31:0]      rf_wd_o,
  output logic             rf_we_o,
  input  logic [31:0]      rf_rd1_i,
  input  logic [31:0]      rf_rd2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [RF_AW-1:0] first_err_addr_o
);

  // An all-zero seed would lock the LFSR at zero forever
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

  // x0 is hardwired in the real RF, so the write sweep can start at x1
  localparam logic [RF_AW-1:0] CNT_FIRST = SKIP_X0 ? RF_AW'(1) : RF_AW'(0);

  bist_state_e      state_q;
  logic [RF_AW-1:0] cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [ERR_W-1:0] err_cnt_d;
  logic [RF_AW-1:0] first_err_q;

  logic [31:0]      lfsr_q;
  logic             lfsr_load;
  logic             lfsr_step;

  logic             is_write;
  logic             is_read;
  logic             start_ok;
  logic             at_last;
  logic             x0_hole;
  logic [31:0]      exp_data;
  logic             err_a;
  logic             err_b;
  logic [1:0]       err_inc;
  logic [ERR_W:0]   err_sum;

  miriscv_lfsr32 u_lfsr (
    .clk_i  (clk_i),
    .reset  (reset),
    .load_i (lfsr_load),
    .seed_i (SEED_EFF),
    .step_i (lfsr_step),
    .q_o    (lfsr_q)
  );

  // Phase decode, LFSR control and read-back comparison
  always_comb begin
    is_write = (state_q == StWrite);
    is_read  = (state_q == StRead);
    start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
    at_last  = (cnt_q == RF_LAST);

    // x0 reads as zero and consumes no LFSR word
    x0_hole  = SKIP_X0 && (cnt_q == '0);
    exp_data = x0_hole ? 32'h0000_0000 : lfsr_q;

    // Restart the sequence when a run begins and again when the read sweep begins
    lfsr_load = start_ok || (is_write && at_last);
    lfsr_step = is_write || (is_read && !x0_hole);

    // Check A: port 1 against the model; check B: port 2 against port 1
    err_a   = is_read && (rf_rd1_i != exp_data);
    err_b   = is_read && (rf_rd2_i != rf_rd1_i);
    err_inc = {1'b0, err_a} + {1'b0, err_b};
    err_sum = {1'b0, err_cnt_q} + {{(ERR_W-1){1'b0}}, err_inc};
    err_cnt_d = err_sum[ERR_W] ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  // Controller FSM with sweep counter, error counter and first-error latch
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StWrite;
            cnt_q   <= CNT_FIRST;
          end
        end
        StWrite: begin
          if (at_last) begin
            state_q <= StRead;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + RF_AW'(1);
          end
        end
        StRead: begin
          err_cnt_q <= err_cnt_d;
          // A zero count means no earlier error, since the count never decreases in a run
          if ((err_a || err_b) && (err_cnt_q == '0)) begin
            first_err_q <= cnt_q;
          end
          if (at_last) begin
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + RF_AW'(1);
          end
        end
        StDone: begin
          if (start_i) begin
            state_q     <= StWrite;
            cnt_q       <= CNT_FIRST;
            err_cnt_q   <= '0;
            first_err_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode straight from state registers; RF signals are quiet outside the sweeps
  always_comb begin
    rf_we_o          = is_write;
    rf_addr3_o       = is_write ? cnt_q : '0;
    rf_wd_o          = is_write ? lfsr_q : 32'h0000_0000;
    rf_addr1_o       = is_read ? cnt_q : '0;
    rf_addr2_o       = is_read ? cnt_q : '0;
    busy_o           = is_write || is_read;
    done_o           = (state_q == StDone);
    pass_o           = done_o && (err_cnt_q == '0);
    err_cnt_o        = err_cnt_q;
    first_err_addr_o = first_err_q;
  end

endmodule
